// File: rtl/seq_alu_pkg.sv
// Shared types for the seq_alu_param multi-cycle ALU: mode and FSM state encodings
// plus the iteration-counter width helper.
package seq_alu_pkg;

    typedef enum logic [2:0] {
        MODE_MULU = 3'd0,
        MODE_DIVU = 3'd1,
        MODE_AND  = 3'd2,
        MODE_OR   = 3'd3,
        MODE_XOR  = 3'd4,
        MODE_MULS = 3'd5,
        MODE_DIVS = 3'd6,
        MODE_RSVD = 3'd7
    } mode_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_MUL   = 3'd1,
        ST_DIV   = 3'd2,
        ST_LOGIC = 3'd3,
        ST_OUT   = 3'd4
    } state_e;

    function automatic int cnt_width(input int w);
        int r;
        r = 0;
        while ((1 << r) < w) r++;
        return r;
    endfunction

endpackage

// File: rtl/seq_alu_param_if.sv
// Request/result bundle between the issue stage (master) and seq_alu_param (slave).
interface seq_alu_param_if #(
    parameter int WIDTH = 32
);
    import seq_alu_pkg::*;

    // valid is sampled only while busy=0; ready is a one-cycle pulse during which
    // out/err are valid. A request raised while busy is dropped, not queued.
    logic               valid;
    logic [2:0]         mode;
    logic [WIDTH-1:0]   in_A;
    logic [WIDTH-1:0]   in_B;
    logic               busy;
    logic               ready;
    logic               err;
    logic [2*WIDTH-1:0] out;
    state_e             state;

    modport master (output valid, mode, in_A, in_B,
                    input  busy, ready, err, out, state);
    modport slave  (input  valid, mode, in_A, in_B,
                    output busy, ready, err, out, state);
endinterface

// File: rtl/seq_alu_shdp.sv
// Shared 2*WIDTH shift register with a WIDTH+1-bit add/subtract stage: one
// shift-add multiply step (shift right) or restoring divide step (shift left) per cycle.
module seq_alu_shdp #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               step,
    input  logic               shift_left,
    input  logic               op_sub,
    input  logic [WIDTH-1:0]   load_a,
    input  logic [WIDTH-1:0]   operand_b,
    output logic [2*WIDTH-1:0] sreg
);
    logic [WIDTH:0]   base;
    logic [WIDTH:0]   addsub;
    logic [WIDTH:0]   sel;
    logic [WIDTH-1:0] lo;
    logic             cond;

    assign lo = sreg[WIDTH-1:0];
    // Divide works on the remainder already shifted left with the next dividend bit.
    assign base   = shift_left ? sreg[2*WIDTH-1:WIDTH-1] : {1'b0, sreg[2*WIDTH-1:WIDTH]};
    assign addsub = op_sub ? (base - {1'b0, operand_b}) : (base + {1'b0, operand_b});
    assign cond   = op_sub ? (base >= {1'b0, operand_b}) : lo[0];
    assign sel    = cond ? addsub : base;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sreg <= '0;
        end else if (load) begin
            sreg <= {{WIDTH{1'b0}}, load_a};
        end else if (step) begin
            if (shift_left) sreg <= {sel[WIDTH-1:0], lo[WIDTH-2:0], cond};
            else            sreg <= {sel, lo[WIDTH-1:1]};
        end
    end
endmodule

// File: rtl/seq_alu_param.sv
// Multi-cycle ALU top: FSM, iteration counter, operand latches, result register.
// Optional SEQ_ALU_SIGNED_EN adds signed multiply/divide on modes 5/6.
module seq_alu_param
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = cnt_width(WIDTH)
) (
    input logic            clk,
    input logic            rst,
    seq_alu_param_if.slave bus
);
    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q;
    logic [WIDTH-1:0]     a_q, b_q, mag_a, mag_b;
    mode_e                mode_q, mode_in;
    logic                 bzero_q;
    logic [2*WIDTH-1:0]   out_q, result, sreg;
    logic                 err_q, result_err;
    logic                 accept, last, step, is_mul_in, is_div_in;
    logic [WIDTH-1:0]     quo, rem;

    assign mode_in = mode_e'(bus.mode);
    assign accept  = (state_q == ST_IDLE) && bus.valid;
    assign last    = (cnt_q == CNT_W'(WIDTH - 1));
    assign step    = (state_q == ST_MUL) || (state_q == ST_DIV);

`ifdef SEQ_ALU_SIGNED_EN
    logic signed_in, sa_in, sb_in, sa_q, sb_q;
    assign signed_in = (mode_in == MODE_MULS) || (mode_in == MODE_DIVS);
    assign sa_in     = signed_in & bus.in_A[WIDTH-1];
    assign sb_in     = signed_in & bus.in_B[WIDTH-1];
    assign mag_a     = sa_in ? -bus.in_A : bus.in_A;
    assign mag_b     = sb_in ? -bus.in_B : bus.in_B;
    assign is_mul_in = (mode_in == MODE_MULU) || (mode_in == MODE_MULS);
    assign is_div_in = (mode_in == MODE_DIVU) || (mode_in == MODE_DIVS);
`else
    assign mag_a     = bus.in_A;
    assign mag_b     = bus.in_B;
    assign is_mul_in = (mode_in == MODE_MULU);
    assign is_div_in = (mode_in == MODE_DIVU);
`endif

    seq_alu_shdp #(.WIDTH(WIDTH)) u_shdp (
        .clk        (clk),
        .rst        (rst),
        .load       (accept),
        .step       (step),
        .shift_left (state_q == ST_DIV),
        .op_sub     (state_q == ST_DIV),
        .load_a     (mag_a),
        .operand_b  (b_q),
        .sreg       (sreg)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (bus.valid) state_d = is_mul_in ? ST_MUL : (is_div_in ? ST_DIV : ST_LOGIC);
            ST_MUL:   if (last) state_d = ST_OUT;
            ST_DIV:   if (last) state_d = ST_OUT;
            ST_LOGIC: state_d = ST_OUT;
            ST_OUT:   state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            mode_q  <= MODE_MULU;
            bzero_q <= 1'b0;
            out_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            cnt_q <= (step && !last) ? cnt_q + 1'b1 : '0;
            if (accept) begin
                a_q     <= bus.in_A;
                b_q     <= mag_b;
                mode_q  <= mode_in;
                bzero_q <= (bus.in_B == '0);
            end
            if (state_q == ST_OUT) begin
                out_q <= result;
                err_q <= result_err;
            end
        end
    end

`ifdef SEQ_ALU_SIGNED_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sa_q <= 1'b0;
            sb_q <= 1'b0;
        end else if (accept) begin
            sa_q <= sa_in;
            sb_q <= sb_in;
        end
    end
`endif

    assign quo = sreg[WIDTH-1:0];
    assign rem = sreg[2*WIDTH-1:WIDTH];

    // Unrecognised modes (including 5/6 without signed support) land in default.
    always_comb begin
        result     = '0;
        result_err = 1'b0;
        case (mode_q)
            MODE_MULU: result = sreg;
            MODE_DIVU: begin
                result     = {rem, quo};
                result_err = bzero_q;
            end
            MODE_AND:  result = {{WIDTH{1'b0}}, a_q & b_q};
            MODE_OR:   result = {{WIDTH{1'b0}}, a_q | b_q};
            MODE_XOR:  result = {{WIDTH{1'b0}}, a_q ^ b_q};
`ifdef SEQ_ALU_SIGNED_EN
            MODE_MULS: result = (sa_q ^ sb_q) ? -sreg : sreg;
            MODE_DIVS: begin
                result     = {(sa_q ? -rem : rem),
                              (bzero_q ? {WIDTH{1'b1}} : ((sa_q ^ sb_q) ? -quo : quo))};
                result_err = bzero_q;
            end
`endif
            default:   result_err = 1'b1;
        endcase
    end

    assign bus.ready = (state_q == ST_OUT);
    assign bus.busy  = (state_q != ST_IDLE);
    assign bus.out   = bus.ready ? result : out_q;
    assign bus.err   = bus.ready ? result_err : err_q;
    assign bus.state = state_q;
endmodule
